// File: rtl/child_dispatch_pkg.sv
// Shared types and constants for the child round-robin dispatcher.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package child_dispatch_pkg;

  // Dispatcher FSM: IDLE waits for a buffered word, OFFER holds a word on one child
  typedef enum logic [0:0] {
    DISP_IDLE  = 1'b0,
    DISP_OFFER = 1'b1
  } disp_state_e;

  // Width of each per-child handshake counter
  localparam int STATS_CNT_W = 16;

  // Index width for a port count; never narrower than one bit
  function automatic int ptr_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/child_rr_dispatcher_if.sv
// Parent-side and child-side handshake bundle of the dispatcher; CHILD_DISPATCH_STATS_EN adds stats signals.
// Latency: n/a (wiring only).
// Backpressure: in_ready toward the parent, per-child out_ready toward the dispatcher.
interface child_rr_dispatcher_if #(
  parameter int DATA_W     = 32,
  parameter int NUM_CHILD  = 5,
  parameter int FIFO_DEPTH = 4
);
  import child_dispatch_pkg::*;

  localparam int PTR_W = ptr_w(NUM_CHILD);
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_W-1:0]     in_data;
  logic [NUM_CHILD-1:0]  out_valid;
  logic [NUM_CHILD-1:0]  out_ready;
  logic [DATA_W-1:0]     out_data;
  logic [PTR_W-1:0]      rr_ptr;
  logic [LVL_W-1:0]      fifo_level;
`ifdef CHILD_DISPATCH_STATS_EN
  logic                                   stats_clr;
  logic [NUM_CHILD-1:0][STATS_CNT_W-1:0]  dispatch_cnt;
`endif

`ifdef CHILD_DISPATCH_STATS_EN
  modport master (
    output in_valid, in_data, out_ready, stats_clr,
    input  in_ready, out_valid, out_data, rr_ptr, fifo_level, dispatch_cnt
  );
  modport slave (
    input  in_valid, in_data, out_ready, stats_clr,
    output in_ready, out_valid, out_data, rr_ptr, fifo_level, dispatch_cnt
  );
`else
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, rr_ptr, fifo_level
  );
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, rr_ptr, fifo_level
  );
`endif

endinterface

// File: rtl/child_dispatch_fifo.sv
// Synchronous circular-buffer FIFO with an occupancy level output.
// Latency: a pushed word is visible at o_rdata the cycle after the push.
// Backpressure: none internally; the caller must not push when full or pop when empty.
module child_dispatch_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  logic [DATA_W-1:0]        i_wdata,
  input  logic                     i_pop,
  output logic [DATA_W-1:0]        o_rdata,
  output logic [$clog2(DEPTH):0]   o_level,
  output logic                     o_empty
);
  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [AW:0]       r_level;

  // Storage is data-only, so it carries no reset
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr_ptr] <= i_wdata;
  end

  // Pointers wrap naturally since DEPTH is a power of two; push+pop keeps the level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({i_push, i_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  assign o_rdata = r_mem[r_rd_ptr];
  assign o_level = r_level;
  assign o_empty = (r_level == '0);

endmodule

// File: rtl/child_rr_dispatcher.sv
// Buffers a parent word stream and deals it to NUM_CHILD children in strict round-robin (stats: CHILD_DISPATCH_STATS_EN).
// Latency: word accepted into an empty dispatcher is offered two edges later; 1 word/cycle when targets are ready.
// Backpressure: the current target's out_ready stalls the offer; in_ready drops when the FIFO is full.
module child_rr_dispatcher
  import child_dispatch_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int NUM_CHILD  = 5,
  parameter int FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  child_rr_dispatcher_if.slave bus
);
  localparam int PTR_W = ptr_w(NUM_CHILD);
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

  disp_state_e           r_state;
  disp_state_e           w_state_nxt;
  logic                  r_in_en;
  logic [PTR_W-1:0]      r_rr_ptr;
  logic [PTR_W-1:0]      w_ptr_inc;
  logic [PTR_W-1:0]      w_ptr_nxt;
  logic [NUM_CHILD-1:0]  r_out_valid;
  logic [NUM_CHILD-1:0]  w_onehot_nxt;
  logic [DATA_W-1:0]     r_out_data;
  logic [DATA_W-1:0]     w_head;
  logic [LVL_W-1:0]      w_level;
  logic                  w_empty;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_hs;

  // in_ready depends only on registered state, never on in_valid
  assign bus.in_ready = r_in_en & (w_level != LVL_W'(FIFO_DEPTH));
  assign w_push       = bus.in_valid & bus.in_ready;

  child_dispatch_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_wdata (bus.in_data),
    .i_pop   (w_pop),
    .o_rdata (w_head),
    .o_level (w_level),
    .o_empty (w_empty)
  );

  // Only the current target's ready counts; other ready bits are ignored
  assign w_hs         = (r_state == DISP_OFFER) & bus.out_ready[r_rr_ptr];
  assign w_ptr_inc    = (r_rr_ptr == PTR_W'(NUM_CHILD - 1)) ? '0 : r_rr_ptr + 1'b1;
  assign w_ptr_nxt    = w_hs ? w_ptr_inc : r_rr_ptr;
  assign w_onehot_nxt = {{(NUM_CHILD-1){1'b0}}, 1'b1} << w_ptr_nxt;

  // Next state and pop: load from IDLE, or reload on a handshake to avoid a bubble
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    case (r_state)
      DISP_IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = DISP_OFFER;
        end
      end
      DISP_OFFER: begin
        if (w_hs) begin
          if (!w_empty) w_pop = 1'b1;
          else          w_state_nxt = DISP_IDLE;
        end
      end
      default: w_state_nxt = DISP_IDLE;
    endcase
  end

  // State, pointer and output register; reset drops out_valid asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= DISP_IDLE;
      r_in_en     <= 1'b0;
      r_rr_ptr    <= '0;
      r_out_valid <= '0;
      r_out_data  <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_in_en  <= 1'b1;
      r_rr_ptr <= w_ptr_nxt;
      if (w_pop) begin
        r_out_valid <= w_onehot_nxt;
        r_out_data  <= w_head;
      end else if (w_hs) begin
        r_out_valid <= '0;
      end
    end
  end

  assign bus.out_valid  = r_out_valid;
  assign bus.out_data   = r_out_data;
  assign bus.rr_ptr     = r_rr_ptr;
  assign bus.fifo_level = w_level;

`ifdef CHILD_DISPATCH_STATS_EN
  logic [NUM_CHILD-1:0][STATS_CNT_W-1:0] r_cnt;

  // Per-child saturating handshake counters; clear wins over a coincident increment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else begin
      for (int i = 0; i < NUM_CHILD; i++) begin
        if (bus.stats_clr) begin
          r_cnt[i] <= '0;
        end else if (w_hs && (r_rr_ptr == PTR_W'(i)) && (r_cnt[i] != '1)) begin
          r_cnt[i] <= r_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign bus.dispatch_cnt = r_cnt;
`endif

endmodule

// File: tb/tb_child_rr_dispatcher.sv
// Self-checking bench for child_rr_dispatcher; CHILD_DISPATCH_STATS_EN enables the stats scenario.
// Latency: n/a.
// Backpressure: exercised through per-child out_ready patterns.
module tb_child_rr_dispatcher;
  import child_dispatch_pkg::*;

  localparam int DW = 32;
  localparam int NC = 5;
  localparam int FD = 4;

  typedef struct {
    int             child;
    logic [DW-1:0]  data;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  child_rr_dispatcher_if #(.DATA_W(DW), .NUM_CHILD(NC), .FIFO_DEPTH(FD)) bus ();

  child_rr_dispatcher #(.DATA_W(DW), .NUM_CHILD(NC), .FIFO_DEPTH(FD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  exp_t sb[$];
  int   exp_ptr = 0;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   hs_total = 0;
  int   hs_cyc_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: one-hot offer matches rr_ptr; every handshake is popped from the scoreboard
  always @(negedge clk) begin
    int p;
    logic [NC-1:0] onehot;
    exp_t e;
    if (rst_n === 1'b1 && bus.out_valid !== '0) begin
      p = int'(bus.rr_ptr);
      onehot = 1;
      onehot = onehot << p;
      checks++;
      if (bus.out_valid !== onehot) begin
        failures++;
        $display("FAIL onehot got=%b exp=%b", bus.out_valid, onehot);
      end
      if (bus.out_ready[p] === 1'b1) begin
        hs_total++;
        hs_cyc_q.push_back(cyc);
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL unexpected_hs child=%0d data=%h exp=none", p, bus.out_data);
        end else begin
          e = sb.pop_front();
          if (p != e.child || bus.out_data !== e.data) begin
            failures++;
            $display("FAIL dispatch got child=%0d data=%h exp child=%0d data=%h",
                     p, bus.out_data, e.child, e.data);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = '0;
`ifdef CHILD_DISPATCH_STATS_EN
    bus.stats_clr = 1'b0;
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    sb.delete();
    exp_ptr = 0;
  endtask

  task automatic push_word(input logic [DW-1:0] d);
    int   n;
    logic acc;
    exp_t e;
    n = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    acc = bus.in_ready;
    while (!acc && n < 50) begin
      tick();
      acc = bus.in_ready;
      n++;
    end
    checks++;
    if (acc) begin
      e.child = exp_ptr;
      e.data  = d;
      sb.push_back(e);
      exp_ptr = (exp_ptr + 1) % NC;
      tick();
    end else begin
      failures++;
      $display("FAIL push_timeout got=in_ready_low exp=accept data=%h", d);
    end
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (sb.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    tick();
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain_timeout got=%0d pending exp=0", sb.size());
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 32'hDEAD_BEEF;
    bus.out_ready = '0;
`ifdef CHILD_DISPATCH_STATS_EN
    bus.stats_clr = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL rst_in_ready got=%b exp=0", bus.in_ready); end
    checks++; if (bus.out_valid !== '0) begin failures++; $display("FAIL rst_out_valid got=%b exp=0", bus.out_valid); end
    checks++; if (bus.rr_ptr !== '0) begin failures++; $display("FAIL rst_rr_ptr got=%0d exp=0", bus.rr_ptr); end
    checks++; if (bus.fifo_level !== '0) begin failures++; $display("FAIL rst_level got=%0d exp=0", bus.fifo_level); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL rel_in_ready got=%b exp=1", bus.in_ready); end
    checks++; if (bus.fifo_level !== '0) begin failures++; $display("FAIL rel_level got=%0d exp=0", bus.fifo_level); end
  endtask

  task automatic test_rr_wrap();
    apply_reset();
    bus.out_ready = '1;
    hs_cyc_q.delete();
    for (int i = 0; i < 7; i++) push_word(32'hA0 + i);
    bus.in_valid = 1'b0;
    wait_drain(30);
    checks++;
    if (hs_cyc_q.size() != 7) begin
      failures++; $display("FAIL rr_hs_count got=%0d exp=7", hs_cyc_q.size());
    end else begin
      checks++;
      if (hs_cyc_q[6] - hs_cyc_q[0] != 6) begin
        failures++; $display("FAIL rr_throughput got=%0d cycles exp=6", hs_cyc_q[6] - hs_cyc_q[0]);
      end
    end
    checks++; if (bus.rr_ptr !== 3'd2) begin failures++; $display("FAIL rr_final_ptr got=%0d exp=2", bus.rr_ptr); end
    checks++; if (bus.out_valid !== '0) begin failures++; $display("FAIL rr_idle got=%b exp=0", bus.out_valid); end
  endtask

  task automatic test_stall();
    apply_reset();
    bus.out_ready = '0;
    for (int i = 0; i < 5; i++) push_word(32'hB0 + i);
    bus.in_valid = 1'b0;
    checks++; if (bus.fifo_level !== 3'd4) begin failures++; $display("FAIL stall_level got=%0d exp=4", bus.fifo_level); end
    checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL stall_in_ready got=%b exp=0", bus.in_ready); end
    checks++; if (bus.out_valid !== 5'b00001) begin failures++; $display("FAIL stall_valid got=%b exp=00001", bus.out_valid); end
    bus.in_valid = 1'b1;
    bus.in_data  = 32'hB5;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL stall_6th_ready got=%b exp=0", bus.in_ready); end
      checks++; if (bus.out_data !== 32'hB0) begin failures++; $display("FAIL stall_data got=%h exp=b0", bus.out_data); end
    end
    bus.in_valid = 1'b0;
    checks++; if (bus.fifo_level !== 3'd4) begin failures++; $display("FAIL stall_level_hold got=%0d exp=4", bus.fifo_level); end
    bus.out_ready = 5'b00001;
    tick();
    bus.out_ready = '0;
    checks++; if (bus.fifo_level !== 3'd3) begin failures++; $display("FAIL release_level got=%0d exp=3", bus.fifo_level); end
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL release_ready got=%b exp=1", bus.in_ready); end
    checks++; if (bus.out_valid !== 5'b00010) begin failures++; $display("FAIL release_valid got=%b exp=00010", bus.out_valid); end
    checks++; if (bus.out_data !== 32'hB1) begin failures++; $display("FAIL release_data got=%h exp=b1", bus.out_data); end
    bus.out_ready = '1;
    wait_drain(30);
  endtask

  task automatic test_no_skip();
    int hs0;
    logic [NC-1:0] bad;
    apply_reset();
    bus.out_ready = 5'b01000;
    push_word(32'hC0);
    bus.in_valid = 1'b0;
    hs0 = hs_total;
    bad = '0;
    tick();
    for (int i = 0; i < 20; i++) begin
      if (bus.out_valid !== 5'b00001 && bad == '0) bad = bus.out_valid | 5'b10000;
      tick();
    end
    checks++; if (bad !== '0) begin failures++; $display("FAIL noskip_valid got=%b exp=00001", bad); end
    checks++; if (hs_total != hs0) begin failures++; $display("FAIL noskip_hs got=%0d exp=%0d", hs_total, hs0); end
    checks++; if (bus.rr_ptr !== '0) begin failures++; $display("FAIL noskip_ptr got=%0d exp=0", bus.rr_ptr); end
    bus.out_ready = '1;
    wait_drain(10);
  endtask

  task automatic test_reset_mid();
    int hs0;
    apply_reset();
    bus.out_ready = '0;
    for (int i = 0; i < 4; i++) push_word(32'hD0 + i);
    bus.in_valid = 1'b0;
    checks++; if (bus.fifo_level !== 3'd3) begin failures++; $display("FAIL mid_level got=%0d exp=3", bus.fifo_level); end
    checks++; if (bus.out_valid !== 5'b00001) begin failures++; $display("FAIL mid_valid got=%b exp=00001", bus.out_valid); end
    rst_n = 1'b0;
    #1;
    checks++; if (bus.out_valid !== '0) begin failures++; $display("FAIL mid_rst_valid got=%b exp=0", bus.out_valid); end
    checks++; if (bus.fifo_level !== '0) begin failures++; $display("FAIL mid_rst_level got=%0d exp=0", bus.fifo_level); end
    checks++; if (bus.rr_ptr !== '0) begin failures++; $display("FAIL mid_rst_ptr got=%0d exp=0", bus.rr_ptr); end
    sb.delete();
    exp_ptr = 0;
    hs0 = hs_total;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    bus.out_ready = '1;
    repeat (10) tick();
    checks++; if (hs_total != hs0) begin failures++; $display("FAIL mid_no_delivery got=%0d exp=%0d", hs_total, hs0); end
    checks++; if (bus.out_valid !== '0) begin failures++; $display("FAIL mid_after_valid got=%b exp=0", bus.out_valid); end
  endtask

`ifdef CHILD_DISPATCH_STATS_EN
  task automatic test_stats();
    int exp_cnt[NC];
    logic nz;
    exp_cnt = '{3, 3, 2, 2, 2};
    apply_reset();
    bus.out_ready = '1;
    for (int i = 0; i < 12; i++) push_word(32'hE0 + i);
    bus.in_valid = 1'b0;
    wait_drain(40);
    for (int i = 0; i < NC; i++) begin
      checks++;
      if (bus.dispatch_cnt[i] !== 16'(exp_cnt[i])) begin
        failures++; $display("FAIL stats_cnt%0d got=%0d exp=%0d", i, bus.dispatch_cnt[i], exp_cnt[i]);
      end
    end
    bus.out_ready = '0;
    push_word(32'hF0);
    bus.in_valid = 1'b0;
    tick();
    checks++; if (bus.out_valid !== 5'b00100) begin failures++; $display("FAIL stats_target got=%b exp=00100", bus.out_valid); end
    bus.out_ready = '1;
    bus.stats_clr = 1'b1;
    tick();
    bus.stats_clr = 1'b0;
    nz = 1'b0;
    for (int i = 0; i < NC; i++) if (bus.dispatch_cnt[i] !== '0) nz = 1'b1;
    checks++; if (nz !== 1'b0) begin failures++; $display("FAIL stats_clr got=nonzero exp=0"); end
    checks++; if (sb.size() != 0) begin failures++; $display("FAIL stats_clr_hs got=%0d pending exp=0", sb.size()); end
    checks++; if (bus.rr_ptr !== 3'd3) begin failures++; $display("FAIL stats_ptr got=%0d exp=3", bus.rr_ptr); end
  endtask
`endif

  initial begin
    test_reset();
    test_rr_wrap();
    test_stall();
    test_no_skip();
    test_reset_mid();
`ifdef CHILD_DISPATCH_STATS_EN
    test_stats();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
